// File: rtl/riscv_v_pkg.sv
// Shared vector-unit types and widths.
// Holds the writeback FIFO entry layout.
package riscv_v_pkg;

    localparam int RISCV_V_DATA_WIDTH     = 128;
    localparam int RISCV_V_NUM_BYTES_DATA = RISCV_V_DATA_WIDTH / 8;
    localparam int RISCV_V_WB_DEPTH       = 4;

    typedef struct packed {
        logic [RISCV_V_DATA_WIDTH-1:0]     data;
        logic [RISCV_V_NUM_BYTES_DATA-1:0] be;
        logic [4:0]                        vd;
        logic                              last;
        logic [RISCV_V_NUM_BYTES_DATA-1:0] zf;
        logic [RISCV_V_NUM_BYTES_DATA-1:0] of;
        logic [RISCV_V_NUM_BYTES_DATA-1:0] cf;
    } riscv_v_wb_entry_t;

endpackage

// File: rtl/riscv_v_sync_fifo.sv
// Generic synchronous FIFO with push/pop/count.
// Head entry is presented combinationally on rdata.
module riscv_v_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;

    assign rdata = mem[rptr];

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointers wrap naturally; count separates full from empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/riscv_v_wb_buffer.sv
// Vector ALU writeback buffer: queues result beats, drains
// them to the VRF, and folds per-instruction flag summaries.
module riscv_v_wb_buffer
    import riscv_v_pkg::*;
#(
    parameter int DATA_W    = RISCV_V_DATA_WIDTH,
    parameter int NUM_BYTES = DATA_W / 8,
    parameter int DEPTH     = RISCV_V_WB_DEPTH,
    parameter int VD_W      = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [DATA_W-1:0]    in_data,
    input  logic [NUM_BYTES-1:0] in_zf,
    input  logic [NUM_BYTES-1:0] in_of,
    input  logic [NUM_BYTES-1:0] in_cf,
    input  logic [NUM_BYTES-1:0] in_be,
    input  logic [VD_W-1:0]      in_vd,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic                 stall,
    output logic                 wr_valid,
    input  logic                 wr_ready,
    output logic [DATA_W-1:0]    wr_data,
    output logic [NUM_BYTES-1:0] wr_be,
    output logic [VD_W-1:0]      wr_vd,
    output logic                 done_valid,
    output logic                 done_zf,
    output logic                 done_of,
    output logic                 done_cf,
    output logic                 ovf_err,
    input  logic                 err_clr
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [DATA_W-1:0]    data;
        logic [NUM_BYTES-1:0] be;
        logic [VD_W-1:0]      vd;
        logic                 last;
        logic [NUM_BYTES-1:0] zf;
        logic [NUM_BYTES-1:0] of;
        logic [NUM_BYTES-1:0] cf;
    } entry_t;

    entry_t           in_entry;
    entry_t           head;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;
    logic             acc_zf;
    logic             acc_of;
    logic             acc_cf;
    logic             nxt_zf;
    logic             nxt_of;
    logic             nxt_cf;

    // Flags are masked with be on entry so disabled lanes fold neutrally.
    always_comb begin
        in_entry      = '0;
        in_entry.data = in_data;
        in_entry.be   = in_be;
        in_entry.vd   = in_vd;
        in_entry.last = in_last;
        in_entry.zf   = in_zf & in_be;
        in_entry.of   = in_of & in_be;
        in_entry.cf   = in_cf & in_be;
    end

    assign in_ready = count < CNT_W'(DEPTH);
    assign stall    = count >= CNT_W'(DEPTH - 1);
    assign wr_valid = count != '0;
    assign push     = in_valid && in_ready;
    assign pop      = wr_valid && wr_ready;
    assign wr_data  = head.data;
    assign wr_be    = head.be;
    assign wr_vd    = head.vd;

    riscv_v_sync_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (in_entry),
        .rdata (head),
        .count (count)
    );

    // Fold the head entry's flags into the running summary.
    always_comb begin
        nxt_zf = acc_zf & (&(head.zf | ~head.be));
        nxt_of = acc_of | (|head.of);
        nxt_cf = acc_cf | (|head.cf);
    end

    // Accumulate per pop; publish and re-arm on the last beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_zf     <= 1'b1;
            acc_of     <= 1'b0;
            acc_cf     <= 1'b0;
            done_valid <= 1'b0;
            done_zf    <= 1'b1;
            done_of    <= 1'b0;
            done_cf    <= 1'b0;
        end else begin
            done_valid <= 1'b0;
            if (pop) begin
                if (head.last) begin
                    done_valid <= 1'b1;
                    done_zf    <= nxt_zf;
                    done_of    <= nxt_of;
                    done_cf    <= nxt_cf;
                    acc_zf     <= 1'b1;
                    acc_of     <= 1'b0;
                    acc_cf     <= 1'b0;
                end else begin
                    acc_zf <= nxt_zf;
                    acc_of <= nxt_of;
                    acc_cf <= nxt_cf;
                end
            end
        end
    end

    // Sticky drop flag; a new drop beats a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_err <= 1'b0;
        end else if (in_valid && !in_ready) begin
            ovf_err <= 1'b1;
        end else if (err_clr) begin
            ovf_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_riscv_v_wb_buffer.sv
// Directed testbench for riscv_v_wb_buffer.
// Inputs change 1ns after the rising edge; outputs sampled there too.
module tb_riscv_v_wb_buffer;

    localparam int DW = 128;
    localparam int NB = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [NB-1:0] in_zf;
    logic [NB-1:0] in_of;
    logic [NB-1:0] in_cf;
    logic [NB-1:0] in_be;
    logic [4:0]    in_vd;
    logic          in_last;
    logic          in_ready;
    logic          stall;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] wr_data;
    logic [NB-1:0] wr_be;
    logic [4:0]    wr_vd;
    logic          done_valid;
    logic          done_zf;
    logic          done_of;
    logic          done_cf;
    logic          ovf_err;
    logic          err_clr;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    riscv_v_wb_buffer dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_zf      (in_zf),
        .in_of      (in_of),
        .in_cf      (in_cf),
        .in_be      (in_be),
        .in_vd      (in_vd),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .stall      (stall),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_data    (wr_data),
        .wr_be      (wr_be),
        .wr_vd      (wr_vd),
        .done_valid (done_valid),
        .done_zf    (done_zf),
        .done_of    (done_of),
        .done_cf    (done_cf),
        .ovf_err    (ovf_err),
        .err_clr    (err_clr)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        in_data  = '0;
        in_zf    = '0;
        in_of    = '0;
        in_cf    = '0;
        in_be    = '1;
        in_vd    = '0;
        in_last  = 1'b0;
        err_clr  = 1'b0;
    endtask

    task automatic beat(input logic [DW-1:0] d, input logic [NB-1:0] zf,
                        input logic [NB-1:0] of, input logic [NB-1:0] cf,
                        input logic [NB-1:0] be, input logic [4:0] vd,
                        input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_zf    = zf;
        in_of    = of;
        in_cf    = cf;
        in_be    = be;
        in_vd    = vd;
        in_last  = last;
    endtask

    task automatic test_reset();
        logic [7:0] got;
        logic [7:0] exp;
        idle_in();
        wr_ready = 1'b1;
        rst = 1'b1;
        step();
        step();
        got = {wr_valid, in_ready, stall, done_valid,
               done_zf, done_of, done_cf, ovf_err};
        exp = 8'b0100_1000;
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=%b", got, exp);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_beat();
        beat('0, '1, '0, '0, '1, 5'd3, 1'b1);
        step();
        idle_in();
        checks++;
        if (wr_valid !== 1'b1 || wr_vd !== 5'd3 || done_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_wr got=%b/%0d/%b exp=1/3/0",
                     wr_valid, wr_vd, done_valid);
        end
        step();
        checks++;
        if ({done_valid, done_zf, done_of, done_cf, wr_valid} !== 5'b11000) begin
            failures++;
            $display("FAIL single_done got=%b exp=11000",
                     {done_valid, done_zf, done_of, done_cf, wr_valid});
        end
        step();
        checks++;
        if (done_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_pulse got=%b exp=0", done_valid);
        end
    endtask

    task automatic test_two_beat();
        beat(128'h11, '0, 16'h0001, '0, '1, 5'd4, 1'b0);
        step();
        beat(128'h22, '0, '0, '0, '1, 5'd4, 1'b1);
        step();
        idle_in();
        checks++;
        if (done_valid !== 1'b0 || wr_data !== 128'h22) begin
            failures++;
            $display("FAIL two_mid got=%b/%h exp=0/22", done_valid, wr_data);
        end
        step();
        checks++;
        if ({done_valid, done_zf, done_of, done_cf} !== 4'b1010) begin
            failures++;
            $display("FAIL two_done got=%b exp=1010",
                     {done_valid, done_zf, done_of, done_cf});
        end
        step();
    endtask

    task automatic test_full_stall();
        logic [1:0] exp_sr [4];
        exp_sr[0] = 2'b01;
        exp_sr[1] = 2'b01;
        exp_sr[2] = 2'b11;
        exp_sr[3] = 2'b10;
        wr_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            beat(DW'(i + 1), '0, '0, '0, '1, 5'(i + 1), 1'b0);
            step();
            checks++;
            if ({stall, in_ready} !== exp_sr[i]) begin
                failures++;
                $display("FAIL fill_%0d stall,ready got=%b exp=%b",
                         i, {stall, in_ready}, exp_sr[i]);
            end
        end
        beat(128'h55, '0, '0, '0, '1, 5'd9, 1'b0);
        step();
        idle_in();
        checks++;
        if (ovf_err !== 1'b1 || wr_data !== 128'h1 || wr_vd !== 5'd1) begin
            failures++;
            $display("FAIL drop got=%b/%h/%0d exp=1/1/1", ovf_err, wr_data, wr_vd);
        end
        err_clr = 1'b1;
        step();
        checks++;
        if (ovf_err !== 1'b0) begin
            failures++;
            $display("FAIL err_clr got=%b exp=0", ovf_err);
        end
        beat(128'h66, '0, '0, '0, '1, 5'd9, 1'b0);
        err_clr = 1'b1;
        step();
        idle_in();
        checks++;
        if (ovf_err !== 1'b1 || wr_data !== 128'h1) begin
            failures++;
            $display("FAIL set_wins got=%b/%h exp=1/1", ovf_err, wr_data);
        end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [4:0] q[$];
        int pushed = 0;
        int drained = 0;
        int dones = 0;
        for (int v = 1; v <= 4; v++) q.push_back(5'(v));
        wr_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && drained < 12; cyc++) begin
            if (done_valid) dones++;
            if (wr_valid) begin
                checks++;
                if (q.size() == 0 || wr_vd !== q[0] || wr_data !== DW'(q[0])) begin
                    failures++;
                    $display("FAIL drain_%0d got=%0d/%h exp=%0d", drained,
                             wr_vd, wr_data, (q.size() != 0) ? q[0] : 5'd0);
                end
                if (q.size() != 0) void'(q.pop_front());
                drained++;
            end
            if (pushed < 8 && in_ready) begin
                beat(DW'(pushed + 5), '0, '0, '0, '1, 5'(pushed + 5),
                     pushed == 7);
                q.push_back(5'(pushed + 5));
                pushed++;
            end else begin
                idle_in();
            end
            step();
        end
        idle_in();
        if (done_valid) dones++;
        checks++;
        if (drained != 12 || q.size() != 0 || ovf_err !== 1'b0 || dones != 1) begin
            failures++;
            $display("FAIL drain_total got=%0d/%0d/%b/%0d exp=12/0/0/1",
                     drained, q.size(), ovf_err, dones);
        end
        step();
    endtask

    task automatic test_masked_zero();
        logic [NB-1:0] bes [2];
        logic          exp_zf [2];
        bes[0] = 16'hFFFE;
        bes[1] = 16'hFFFF;
        exp_zf[0] = 1'b1;
        exp_zf[1] = 1'b0;
        wr_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            beat('0, 16'hFFFE, '0, '0, bes[i], 5'd7, 1'b1);
            step();
            idle_in();
            step();
            checks++;
            if (done_valid !== 1'b1 || done_zf !== exp_zf[i]) begin
                failures++;
                $display("FAIL mask_zf_%0d got=%b/%b exp=1/%b",
                         i, done_valid, done_zf, exp_zf[i]);
            end
        end
        beat(128'hAB, 16'h0000, '1, '1, '0, 5'd8, 1'b1);
        step();
        idle_in();
        checks++;
        if (wr_valid !== 1'b1 || wr_be !== 16'h0 || wr_data !== 128'hAB) begin
            failures++;
            $display("FAIL be0_write got=%b/%h/%h exp=1/0000/ab",
                     wr_valid, wr_be, wr_data);
        end
        step();
        checks++;
        if ({done_valid, done_zf, done_of, done_cf} !== 4'b1100) begin
            failures++;
            $display("FAIL be0_flags got=%b exp=1100",
                     {done_valid, done_zf, done_of, done_cf});
        end
        step();
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        wr_ready = 1'b1;
        beat(128'h1, '0, 16'h0010, '1, '1, 5'd2, 1'b0);
        step();
        beat(128'h2, '0, '0, '0, '1, 5'd2, 1'b0);
        step();
        idle_in();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({wr_valid, in_ready, stall, done_valid} !== 4'b0100) begin
            failures++;
            $display("FAIL rst_mid got=%b exp=0100",
                     {wr_valid, in_ready, stall, done_valid});
        end
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (done_valid) seen++;
            step();
        end
        checks++;
        if (seen != 0 || wr_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_no_done got=%0d/%b exp=0/0", seen, wr_valid);
        end
        beat('0, '1, '0, '0, '1, 5'd2, 1'b1);
        step();
        idle_in();
        step();
        checks++;
        if ({done_valid, done_zf, done_of, done_cf} !== 4'b1100) begin
            failures++;
            $display("FAIL rst_acc got=%b exp=1100",
                     {done_valid, done_zf, done_of, done_cf});
        end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_two_beat();
        test_full_stall();
        test_back_to_back();
        test_masked_zero();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/riscv_v_wb_buffer.md
# riscv_v_wb_buffer

Writeback buffer on the consumer side of the vector arithmetic ALU result interface. It captures each ALU result beat (data plus per-byte zero/overflow/carry flags), queues it in a small FIFO, and drains it to the vector register file write port under a valid/ready handshake. It also folds per-instruction flag summaries across all beats of an instruction and reports them on a one-cycle done pulse. Issue logic uses its `stall` output to throttle the ALU, which has no backpressure of its own.

## Interface
Parameters:
- `DATA_W`, default `RISCV_V_DATA_WIDTH` (128): result data width.
- `NUM_BYTES`, default `DATA_W/8`: byte lanes, also the flag width.
- `DEPTH`, default 4: FIFO entries; must be a power of two and at least 2.
- `VD_W`, default 5: destination register index width.

Ports (name, direction, width, meaning):
- `clk`, in, 1: clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `in_valid`, in, 1: ALU result beat present (`result.valid`).
- `in_data`, in, `DATA_W`: ALU result data.
- `in_zf` / `in_of` / `in_cf`, in, `NUM_BYTES` each: per-byte ALU flags.
- `in_be`, in, `NUM_BYTES`: byte write enables (mask/tail already applied).
- `in_vd`, in, `VD_W`: destination register.
- `in_last`, in, 1: final beat of the instruction.
- `in_ready`, out, 1: a beat will be accepted this cycle.
- `stall`, out, 1: tells issue to stop sending beats.
- `wr_valid`, out, 1: VRF write request.
- `wr_ready`, in, 1: VRF accepts the write.
- `wr_data`, out, `DATA_W`: write data.
- `wr_be`, out, `NUM_BYTES`: write byte enables.
- `wr_vd`, out, `VD_W`: write register.
- `done_valid`, out, 1: one-cycle pulse, instruction retired.
- `done_zf`, out, 1: every enabled byte of every beat was zero-flagged.
- `done_of`, out, 1: any enabled byte overflowed.
- `done_cf`, out, 1: any enabled byte carried.
- `ovf_err`, out, 1: sticky; a beat was dropped.
- `err_clr`, in, 1: synchronous clear of `ovf_err`.

## Operation
- FIFO entry fields: data, be, vd, last, and the three flag vectors ANDed with be.
- Push: `in_valid && in_ready`. Pop: `wr_valid && wr_ready`.
- `in_ready` = count < DEPTH. It does not depend on `wr_ready`, so there is no pass-through when full.
- `stall` = count >= DEPTH-1. This leaves one slot of slack for a beat already in flight.
- If `in_valid` arrives while `!in_ready`, the beat is dropped and `ovf_err` is set. `ovf_err` stays set until `err_clr` or reset. If a drop and `err_clr` happen in the same cycle, the set wins.
- The write outputs are driven combinationally from the FIFO head. `wr_valid` = count != 0.
- Flag accumulators are updated on each pop:
  - `acc_zf &= &(zf | ~be)`
  - `acc_of |= |of`
  - `acc_cf |= |cf`
- On a pop of a `last` entry, the `done_*` registers load the final accumulated values, including that entry's contribution. The accumulators then return to their idle values: zf = 1, of = 0, cf = 0.
- A beat with `in_be` = 0 is still queued and still written. It contributes neutrally to the flag summary.
- Read and write pointers are `$clog2(DEPTH)` bits and wrap naturally. A separate count register of `$clog2(DEPTH)+1` bits distinguishes full from empty.
- Simultaneous push and pop leaves the count unchanged. This is legal at any occupancy except full, where push is blocked.

## Timing
- Reset values: `wr_valid`=0, `in_ready`=1, `stall`=0, `done_valid`=0, `done_zf`=1, `done_of`=0, `done_cf`=0, `ovf_err`=0. Pointers and count are 0, and the accumulators are at their idle values.
- Latency: a beat pushed at edge N appears on `wr_valid` in cycle N+1. The minimum input-to-VRF latency is one cycle.
- `done_valid` is asserted in the cycle after the popping edge of the `last` entry, for exactly one cycle. `done_*` hold their values until the next done.
- Throughput: one beat per cycle when `wr_ready` is held high.
- While `wr_valid` is high and `wr_ready` is low, the write outputs hold stable.
- Reset asserted mid-instruction discards all entries and partial accumulators immediately. No done pulse is produced.

## Structure
- The `riscv_v_pkg` package holds:
  - `riscv_v_wb_entry_t`, the packed FIFO entry.
  - `RISCV_V_WB_DEPTH`.
  - The existing `RISCV_V_DATA_WIDTH` and `RISCV_V_NUM_BYTES_DATA`.
- One sub-module: `riscv_v_sync_fifo`, a generic DEPTH×entry FIFO with push/pop/count. Flag folding and the done logic stay in the top module.

## Test plan
1. Single beat, `in_last`=1, data=0, zf all ones, be all ones, `wr_ready`=1 → `wr_valid` in cycle 1; `done_valid` in cycle 2 with zf=1, of=0, cf=0.
2. Two-beat instruction with `of` = 0x0001 on beat 0 only → one `done_valid` after beat 1 is popped, with `done_of`=1.
3. Hold `wr_ready`=0 and push 4 beats → `stall` rises after the 3rd push, `in_ready` drops after the 4th. A 5th `in_valid` sets `ovf_err`; `wr_data` stays equal to beat 0.
4. FIFO full, then release `wr_ready` while continuously pushing 8 beats → the entries drain in order with no loss. Pointers wrap and each `wr_vd` matches its push.
5. Beat with zf=0 only on a byte whose be=0 → `done_zf`=1. Same beat with be=1 on that byte → `done_zf`=0.
6. Assert `rst` after 2 of 3 beats → outputs return to reset values, and no `done_valid` appears after `rst` is released.
